// File: rtl/grant_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grant_decoder_pkg
//  Description : Shared arbiter types: grant FSM states and grant encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package grant_decoder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int c_OUT_BINARY = 0;
    localparam int c_OUT_ONEHOT = 1;

endpackage
`default_nettype wire

// File: rtl/grant_encode.sv
`default_nettype none
// ============================================================================
//  Module      : grant_encode
//  Description : Combinational binary-index to grant-vector encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module grant_encode
    import grant_decoder_pkg::*;
#(
    parameter  int N           = 4,
    parameter  int OUTPUT_TYPE = c_OUT_ONEHOT,
    localparam int IW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IW-1:0] i_idx,
    output logic [N-1:0]  o_grant
);

    generate
        if (OUTPUT_TYPE == c_OUT_ONEHOT) begin : g_onehot
            always_comb begin
                o_grant = '0;
                for (int i = 0; i < N; i++) begin
                    o_grant[i] = (i_idx == IW'(i));
                end
            end
        end else begin : g_binary
            // N is at least 2, so the index is always strictly narrower than the vector
            assign o_grant = {{(N-IW){1'b0}}, i_idx};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/grant_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : grant_decoder
//  Description : Holds an arbiter winner as a registered grant, with release,
//                direct handover, hold-time limit and invalid-index reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module grant_decoder
    import grant_decoder_pkg::*;
#(
    parameter  int N           = 4,
    parameter  int OUTPUT_TYPE = c_OUT_ONEHOT,
    parameter  int HOLD_MAX    = 16,
    localparam int IW          = (N > 1) ? $clog2(N) : 1,
    localparam int CW          = $clog2(HOLD_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          ack,
    input  logic [IW-1:0] idx,
    input  logic          release_i,
    output logic [N-1:0]  grant,
    output logic          busy,
    output logic          timeout,
    output logic          err
);

    localparam logic [IW:0]   c_N_CHAN   = (IW+1)'(N);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(HOLD_MAX - 1);

    state_t        r_state_q,   w_state_d;
    logic [IW-1:0] r_held_q,    w_held_d;
    logic [CW-1:0] r_cnt_q,     w_cnt_d;
    logic [N-1:0]  r_grant_q,   w_grant_d;
    logic          r_busy_q,    w_busy_d;
    logic          r_timeout_q, w_timeout_d;
    logic          r_err_q,     w_err_d;

    logic          w_load_req;
    logic          w_accept;
    logic [N-1:0]  w_enc;

    assign w_load_req = load & ack;
    assign w_accept   = w_load_req & ({1'b0, idx} < c_N_CHAN);

    always_comb begin
        w_state_d   = r_state_q;
        w_held_d    = r_held_q;
        w_cnt_d     = r_cnt_q;
        w_timeout_d = 1'b0;
        w_err_d     = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = ST_HOLD;
                    w_held_d  = idx;
                    w_cnt_d   = '0;
                end else begin
                    w_err_d   = w_load_req;
                end
            end
            ST_HOLD: begin
                // Release wins over the hold limit; a new load is only considered alongside a release
                if (release_i) begin
                    if (w_accept) begin
                        w_held_d  = idx;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = ST_IDLE;
                        w_cnt_d   = '0;
                        w_err_d   = w_load_req;
                    end
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_state_d   = ST_IDLE;
                    w_cnt_d     = '0;
                    w_timeout_d = 1'b1;
                end else begin
                    w_cnt_d     = r_cnt_q + CW'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    grant_encode #(
        .N           (N),
        .OUTPUT_TYPE (OUTPUT_TYPE)
    ) u_grant_encode (
        .i_idx   (w_held_d),
        .o_grant (w_enc)
    );

    assign w_busy_d  = (w_state_d == ST_HOLD);
    assign w_grant_d = w_busy_d ? w_enc : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_held_q    <= '0;
            r_cnt_q     <= '0;
            r_grant_q   <= '0;
            r_busy_q    <= 1'b0;
            r_timeout_q <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_held_q    <= w_held_d;
            r_cnt_q     <= w_cnt_d;
            r_grant_q   <= w_grant_d;
            r_busy_q    <= w_busy_d;
            r_timeout_q <= w_timeout_d;
            r_err_q     <= w_err_d;
        end
    end

    assign grant   = r_grant_q;
    assign busy    = r_busy_q;
    assign timeout = r_timeout_q;
    assign err     = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_grant_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grant_decoder
//  Description : Self-checking bench for grant_decoder in three configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grant_decoder;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld [3];
    logic        ak [3];
    logic        rl [3];
    logic [31:0] ix [3];
    logic        busy [3];
    logic        to [3];
    logic        err [3];
    logic [3:0]  grant_a;
    logic [4:0]  grant_b;
    logic [7:0]  grant_c;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state: m_age counts cycles the grant has been visible
    int m_busy [3];
    int m_held [3];
    int m_age  [3];
    int m_to   [3];
    int m_err  [3];

    always #5 clk = ~clk;

    grant_decoder #(.N(4), .OUTPUT_TYPE(1), .HOLD_MAX(4)) u_dut_a (
        .clk(clk), .rst(rst), .load(ld[0]), .ack(ak[0]), .idx(ix[0][1:0]),
        .release_i(rl[0]), .grant(grant_a), .busy(busy[0]), .timeout(to[0]), .err(err[0]));

    grant_decoder #(.N(5), .OUTPUT_TYPE(1), .HOLD_MAX(6)) u_dut_b (
        .clk(clk), .rst(rst), .load(ld[1]), .ack(ak[1]), .idx(ix[1][2:0]),
        .release_i(rl[1]), .grant(grant_b), .busy(busy[1]), .timeout(to[1]), .err(err[1]));

    grant_decoder #(.N(8), .OUTPUT_TYPE(0), .HOLD_MAX(8)) u_dut_c (
        .clk(clk), .rst(rst), .load(ld[2]), .ack(ak[2]), .idx(ix[2][2:0]),
        .release_i(rl[2]), .grant(grant_c), .busy(busy[2]), .timeout(to[2]), .err(err[2]));

    function automatic int p_n(int k);
        return (k == 0) ? 4 : (k == 1) ? 5 : 8;
    endfunction
    function automatic int p_ot(int k);
        return (k == 2) ? 0 : 1;
    endfunction
    function automatic int p_hm(int k);
        return (k == 0) ? 4 : (k == 1) ? 6 : 8;
    endfunction
    function automatic int p_iw(int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic logic [31:0] act_grant(int k);
        if (k == 0) return {28'd0, grant_a};
        if (k == 1) return {27'd0, grant_b};
        return {24'd0, grant_c};
    endfunction

    function automatic logic [31:0] exp_grant(int k);
        if (m_busy[k] == 0) return 32'd0;
        if (p_ot(k) == 1)   return 32'd1 << m_held[k];
        return 32'(m_held[k]);
    endfunction

    task automatic chk(string nm, int k, logic [31:0] eg, logic eb, logic et, logic ee);
        logic [31:0] ag;
        ag = act_grant(k);
        n_total++;
        if (ag === eg && busy[k] === eb && to[k] === et && err[k] === ee)
            n_pass++;
        else
            $display("FAIL %s dut%0d: got grant=%0h busy=%b timeout=%b err=%b, want grant=%0h busy=%b timeout=%b err=%b",
                     nm, k, ag, busy[k], to[k], err[k], eg, eb, et, ee);
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            ld[k] = 1'b0; ak[k] = 1'b0; rl[k] = 1'b0; ix[k] = 32'd0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_held[k] = 0; m_age[k] = 0; m_to[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_step(int k);
        bit req;
        bit ok;
        req = ld[k] && ak[k];
        ok  = req && (ix[k] < 32'(p_n(k)));
        m_to[k]  = 0;
        m_err[k] = 0;
        if (m_busy[k] != 0) begin
            if (rl[k]) begin
                if (ok) begin
                    m_held[k] = int'(ix[k]);
                    m_age[k]  = 1;
                end else begin
                    m_busy[k] = 0;
                    m_err[k]  = int'(req);
                end
            end else if (m_age[k] == p_hm(k)) begin
                m_busy[k] = 0;
                m_to[k]   = 1;
            end else begin
                m_age[k]++;
            end
        end else if (ok) begin
            m_busy[k] = 1;
            m_held[k] = int'(ix[k]);
            m_age[k]  = 1;
        end else begin
            m_err[k] = int'(req);
        end
    endtask

    typedef struct {
        logic       ld, ak, rl;
        logic [1:0] ix;
        logic [3:0] g;
        logic       b, t, e;
    } vec_t;

    function automatic vec_t mk(logic l, logic a, logic r, logic [1:0] i,
                                logic [3:0] g, logic b, logic t, logic e);
        vec_t v;
        v.ld = l; v.ak = a; v.rl = r; v.ix = i; v.g = g; v.b = b; v.t = t; v.e = e;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        tbl[0]  = mk(H, H, L, 2'd2, 4'b0100, H, L, L);
        tbl[1]  = mk(H, H, H, 2'd0, 4'b0001, H, L, L);
        tbl[2]  = mk(H, H, L, 2'd1, 4'b0001, H, L, L);
        tbl[3]  = mk(L, L, L, 2'd0, 4'b0001, H, L, L);
        tbl[4]  = mk(L, L, L, 2'd0, 4'b0001, H, L, L);
        tbl[5]  = mk(H, H, L, 2'd3, 4'b0000, L, H, L);
        tbl[6]  = mk(L, L, L, 2'd0, 4'b0000, L, L, L);
        tbl[7]  = mk(L, L, H, 2'd0, 4'b0000, L, L, L);
        tbl[8]  = mk(H, L, L, 2'd3, 4'b0000, L, L, L);
        tbl[9]  = mk(H, H, L, 2'd3, 4'b1000, H, L, L);
        tbl[10] = mk(L, L, H, 2'd0, 4'b0000, L, L, L);
        tbl[11] = mk(H, H, L, 2'd1, 4'b0010, H, L, L);
        tbl[12] = mk(L, L, L, 2'd0, 4'b0010, H, L, L);
        tbl[13] = mk(L, L, L, 2'd0, 4'b0010, H, L, L);
        tbl[14] = mk(L, L, L, 2'd0, 4'b0010, H, L, L);
        tbl[15] = mk(H, H, H, 2'd2, 4'b0100, H, L, L);
        tbl[16] = mk(L, L, H, 2'd0, 4'b0000, L, L, L);

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("reset_state", k, 32'd0, L, L, L);
        rst = 1'b0;

        // Table: first row is accepted on the first edge after reset release
        for (int i = 0; i < 17; i++) begin
            ld[0] = tbl[i].ld; ak[0] = tbl[i].ak; rl[0] = tbl[i].rl;
            ix[0] = {30'd0, tbl[i].ix};
            step();
            chk($sformatf("tbl_row%0d", i), 0, {28'd0, tbl[i].g}, tbl[i].b, tbl[i].t, tbl[i].e);
        end
        idle_inputs();

        // Out-of-range index on the five-channel instance
        ld[1] = 1'b1; ak[1] = 1'b1; ix[1] = 32'd6;
        step();
        chk("err_idle", 1, 32'd0, L, L, H);
        idle_inputs();
        step();
        chk("err_one_cycle", 1, 32'd0, L, L, L);
        ld[1] = 1'b1; ak[1] = 1'b1; ix[1] = 32'd4;
        step();
        chk("accept_idx4", 1, 32'b10000, H, L, L);
        ld[1] = 1'b1; ak[1] = 1'b1; ix[1] = 32'd7;
        step();
        chk("bad_load_no_release", 1, 32'b10000, H, L, L);
        rl[1] = 1'b1;
        step();
        chk("release_bad_handover", 1, 32'd0, L, L, H);
        idle_inputs();

        // Binary encoding and asynchronous reset mid-hold
        ld[2] = 1'b1; ak[2] = 1'b1; ix[2] = 32'd5;
        step();
        chk("binary_idx5", 2, 32'b00000101, H, L, L);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_clear", 2, 32'd0, L, L, L);
        step();
        rst = 1'b0;
        step();
        chk("after_rst_idle", 2, 32'd0, L, L, L);
        step();
        chk("after_rst_no_timeout", 2, 32'd0, L, L, L);

        // Randomised run against the behavioural model
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                ld[k] = 1'($urandom_range(0, 1));
                ak[k] = ($urandom_range(0, 3) != 0);
                rl[k] = ($urandom_range(0, 9) == 0);
                ix[k] = $urandom_range(0, (1 << p_iw(k)) - 1);
            end
            @(posedge clk);
            for (int k = 0; k < 3; k++) model_step(k);
            #1;
            for (int k = 0; k < 3; k++)
                chk($sformatf("rand_c%0d", c), k, exp_grant(k), m_busy[k] != 0,
                    m_to[k] != 0, m_err[k] != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grant_decoder.md
GRANT_DECODER -- requirements
Module: grant_decoder

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning number of request channels (2..32).
REQ-002 The module SHALL have parameter OUTPUT_TYPE, default 1, meaning grant encoding: 1 = one-hot on grant[N-1:0], 0 = binary index in grant[IW-1:0] with upper bits 0.
REQ-003 The module SHALL have parameter HOLD_MAX, default 16, meaning maximum cycles a grant may stay asserted (2..255).
REQ-004 The module SHALL derive localparam IW = max(1, clog2(N)); CW = clog2(HOLD_MAX+1).
REQ-005 The module SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 The module SHALL have port load  input  1  arbiter winner available on idx.
REQ-008 The module SHALL have port ack  input  1  downstream accepts a new grant this cycle.
REQ-009 The module SHALL have port idx  input  IW  binary winner index.
REQ-010 The module SHALL have port release_i  input  1  current grant holder finished.
REQ-011 The module SHALL have port grant  output  N  registered grant, encoded per OUTPUT_TYPE.
REQ-012 The module SHALL have port busy  output  1  high while a grant is held.
REQ-013 The module SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.
REQ-014 The module SHALL have port err  output  1  one-cycle pulse when a load with idx >= N is rejected.

Function
REQ-015 The module SHALL implement a two-state FSM: IDLE (grant = 0, busy = 0) and HOLD (grant = encoded held index, busy = 1).
REQ-016 A load is accepted when load & ack & (idx < N); acceptance SHALL be visible on grant/busy one cycle later (latency 1).
REQ-017 IDLE -> HOLD on accepted load; held index := idx, hold counter := 0.
REQ-018 In HOLD the hold counter SHALL increment by 1 every cycle, saturating never (it resets before overflow).
REQ-019 HOLD -> IDLE on release_i without accepted load; grant and busy SHALL be 0 the next cycle.
REQ-020 HOLD with release_i and accepted load in the same cycle SHALL hand over directly: stay HOLD, held index := idx, counter := 0, no idle cycle.
REQ-021 In HOLD, load without release_i SHALL be ignored (no change to held index or counter, no err).
REQ-022 When the counter equals HOLD_MAX-1 and release_i is low, the FSM SHALL go to IDLE and pulse timeout for exactly the next cycle; a simultaneous load SHALL be ignored.
REQ-023 release_i on the HOLD_MAX-1 cycle SHALL take priority: normal release/handover, no timeout.
REQ-024 release_i in IDLE SHALL be ignored.
REQ-025 load & ack with idx >= N (only possible when N is not a power of two) SHALL leave state unchanged and pulse err for the next cycle, in either state where the load would otherwise be considered.
REQ-026 grant SHALL be a registered output; never more than one bit set when OUTPUT_TYPE = 1.
REQ-027 timeout and err SHALL be registered single-cycle pulses.

Reset
REQ-028 While rst is high: state = IDLE, grant = 0, busy = 0, timeout = 0, err = 0, counter = 0, held index = 0.
REQ-029 Reset asserted mid-HOLD SHALL clear grant immediately (asynchronously), no timeout pulse.
REQ-030 First accepted load is possible on the first rising edge after rst deasserts.

Structure
REQ-031 State encoding (IDLE/HOLD) and the OUTPUT_TYPE codes SHALL live in the shared arbiter package.
REQ-032 The binary-to-grant encoding SHALL be a combinational sub-module grant_encode (parameters N, OUTPUT_TYPE) feeding the grant register.

Verification
REQ-033 N=4, OUTPUT_TYPE=1: load=ack=1, idx=2 in IDLE -> next cycle grant=4'b0100, busy=1.
REQ-034 HOLD idx=2, release_i=1 with load=ack=1, idx=0 -> next cycle grant=4'b0001, busy stays 1, counter 0.
REQ-035 HOLD_MAX=4, grant held without release -> grant cleared 4 cycles after acceptance, timeout high exactly 1 cycle.
REQ-036 N=5, load=ack=1, idx=6 -> err pulse 1 cycle, grant stays 0.
REQ-037 OUTPUT_TYPE=0, N=8, accept idx=5 -> grant=8'b00000101; rst pulsed mid-HOLD -> grant=0 before next edge, no timeout.
REQ-038 HOLD, load=1 ack=1 release_i=0 idx=1 -> grant unchanged, no err.
